// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM state encoding and default width.
package divu_pkg;

   localparam int DIVU_WIDTH = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divu_step.sv
// One restoring division step: shift {rem,quo} left by one, then subtract the divisor if it fits.
module divu_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             fits;

   // rem_in is always below the divisor, so the top shifted bit stays zero; it is kept for a full-width compare
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      diff    = shifted - {2'b00, divisor};
      fits    = (shifted >= {2'b00, divisor});
      rem_out = fits ? (WIDTH+1)'(diff) : (WIDTH+1)'(shifted);
      quo_out = {quo_in[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/divu_seq.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with start/busy/done handshake.
module divu_seq
   import divu_pkg::*;
#(
   parameter int WIDTH = DIVU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dsr;
   logic             dz_pend;
   logic [WIDTH:0]   rem_nx;
   logic [WIDTH-1:0] quo_nx;

   divu_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .divisor (dsr),
      .rem_out (rem_nx),
      .quo_out (quo_nx)
   );

   // A zero divisor waits one extra idle cycle (dz_pend) so its done lands after the second edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dsr         <= '0;
         dz_pend     <= 1'b0;
         q           <= '0;
         r           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (dz_pend) begin
                  dz_pend     <= 1'b0;
                  q           <= '1;
                  r           <= quo;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else if (start) begin
                  rem         <= '0;
                  quo         <= dividend;
                  dsr         <= divisor;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                  if (divisor != '0) begin
                     busy  <= 1'b1;
                     state <= S_RUN;
                  end else begin
                     dz_pend <= 1'b1;
                     state   <= S_IDLE;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  q     <= quo_nx;
                  r     <= rem_nx[WIDTH-1:0];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divu_seq.sv
// Directed and randomized checks of divu_seq against a plain-arithmetic division model.
module tb_divu_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   int   tests = 0;
   int   fails = 0;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   divu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .q           (q),
      .r           (r),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         tests++;
         assert (!(busy === 1'b1 && done === 1'b1)) else begin
            fails++;
            $error("FAIL busy_done_overlap observed=%b%b expected=not both", busy, done);
         end
         tests++;
         assert (!(prev_done === 1'b1 && done === 1'b1)) else begin
            fails++;
            $error("FAIL done_pulse observed=2 cycles expected=1 cycle");
         end
      end
      prev_done = done;
   end

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eq, output logic [W-1:0] er,
                                 output logic ez, output int lat);
      if (b == 0) begin
         eq = '1; er = a; ez = 1'b1; lat = 1;
      end else begin
         eq = a / b; er = a % b; ez = 1'b0; lat = W;
      end
   endfunction

   task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Called at the negedge just after the accepting edge; returns at the negedge where done is seen
   task automatic wait_done(output int cyc, output int bc);
      cyc = 0;
      bc  = 0;
      forever begin
         if (busy === 1'b1) bc++;
         if (done === 1'b1 || cyc >= 200) break;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eq, er;
      logic         ez;
      int           lat, cyc, bc;
      model(a, b, eq, er, ez, lat);
      start_div(a, b);
      wait_done(cyc, bc);
      chk({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk({tag, "_q"}, 64'(q), 64'(eq));
      chk({tag, "_r"}, 64'(r), 64'(er));
      chk({tag, "_dz"}, 64'(div_by_zero), 64'(ez));
   endtask

   initial begin
      int           cyc, bc, sel;
      logic [W-1:0] a, b;

      reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #1;
      chk("rst_q", 64'(q), 64'd0);
      chk("rst_r", 64'(r), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_by_zero), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // 7/2 with busy-cycle count
      start_div(32'd7, 32'd2);
      wait_done(cyc, bc);
      chk("t1_lat", 64'(cyc), 64'd32);
      chk("t1_busy_cycles", 64'(bc), 64'd32);
      chk("t1_q", 64'(q), 64'd3);
      chk("t1_r", 64'(r), 64'd1);
      chk("t1_dz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      chk("t1_done_drop", 64'(done), 64'd0);

      run_check("t2a", 32'd2200000000, 32'd3);
      chk("t2a_q_const", 64'(q), 64'd733333333);
      run_check("t2b", 32'hFFFFFFFF, 32'd1);
      run_check("t2c", 32'd3, 32'd7);

      // divide by zero
      start_div(32'd5, 32'd0);
      wait_done(cyc, bc);
      chk("t3_lat", 64'(cyc), 64'd1);
      chk("t3_busy_cycles", 64'(bc), 64'd0);
      chk("t3_q", 64'(q), 64'hFFFFFFFF);
      chk("t3_r", 64'(r), 64'd5);
      chk("t3_dz", 64'(div_by_zero), 64'd1);

      // start during RUN is ignored; start in DONE is accepted
      start_div(32'd100, 32'd7);
      repeat (3) @(negedge clk);
      dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bc);
      chk("t4_q", 64'(q), 64'd14);
      chk("t4_r", 64'(r), 64'd2);
      dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4_b2b_busy", 64'(busy), 64'd1);
      chk("t4_b2b_q_held", 64'(q), 64'd14);
      wait_done(cyc, bc);
      chk("t4_b2b_lat", 64'(cyc), 64'd32);
      chk("t4_b2b_q", 64'(q), 64'd3);
      chk("t4_b2b_r", 64'(r), 64'd0);

      // asynchronous reset in the middle of a division
      start_div(32'hFFFFFFFF, 32'h80000000);
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t5_q", 64'(q), 64'd0);
      chk("t5_r", 64'(r), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_done", 64'(done), 64'd0);
      chk("t5_dz", 64'(div_by_zero), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) begin
            chk("t5_abandoned", {62'd0, busy, done}, 64'd0);
            break;
         end
      end
      run_check("t5_after", 32'd10, 32'd4);

      // randomized pairs with a mix of divisor ranges
      for (int i = 0; i < 1000; i++) begin
         sel = int'($urandom_range(0, 3));
         a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
         case (sel)
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = W'($urandom);
            default: b = W'($urandom) | 32'h80000000;
         endcase
         run_check("rand", a, b);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
